k_wput_arb: RTL and testbench



---
 rtl/k_fifo_pkg.sv | 20 ++
 rtl/k_rr_pick.sv | 34 +++
 rtl/k_wput_arb.sv | 108 ++++++++++
 tb/tb_k_wput_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: burst arbiter state
// encoding and a width helper for index/counter sizing.
package k_fifo_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  // Number of bits needed to index `value` items (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/k_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last_i`,
// wrapping modulo num_req, with `last_i` itself considered last.
module k_rr_pick
  import k_fifo_pkg::*;
#(
  parameter int num_req = 4,
  parameter int ID_W    = clog2(num_req)
) (
  input  logic [num_req-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [num_req-1:0] pick_o,
  output logic [ID_W-1:0]    pick_id_o,
  output logic               any_o
);

  always_comb begin
    int j;
    j         = 0;
    pick_o    = '0;
    pick_id_o = '0;
    any_o     = 1'b0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = num_req; k >= 1; k--) begin
      j = (int'(last_i) + k) % num_req;
      if (req_i[ID_W'(j)]) begin
        pick_o            = '0;
        pick_o[ID_W'(j)]  = 1'b1;
        pick_id_o         = ID_W'(j);
        any_o             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/k_wput_arb.sv
// Round-robin arbiter sharing the FIFO write port among num_req requesters,
// granting bounded bursts and never writing while the FIFO is full.
module k_wput_arb
  import k_fifo_pkg::*;
#(
  parameter int num_req   = 4,
  parameter int data_size = 8,
  parameter int max_burst = 4
) (
  input  logic                           wclk,
  input  logic                           wrst_n,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*data_size-1:0]   req_data,
  output logic [num_req-1:0]             ack,
  input  logic                           wfull,
  output logic                           wput,
  output logic [data_size-1:0]           wdata,
  output logic [num_req-1:0]             gnt,
  output logic [clog2(num_req)-1:0]      gnt_id,
  output logic                           busy
);

  localparam int ID_W   = clog2(num_req);
  localparam int BCNT_W = clog2(max_burst) + 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(max_burst - 1);
  localparam logic [ID_W-1:0]   RST_ID    = ID_W'(num_req - 1);

  state_e              state_q, state_d;
  logic [num_req-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

  logic [num_req-1:0]  pick;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic                grantee_req;
  logic [data_size-1:0] slot [num_req];

  generate
    for (genvar gi = 0; gi < num_req; gi++) begin : g_slot
      assign slot[gi] = req_data[gi*data_size +: data_size];
    end
  endgenerate

  k_rr_pick #(
    .num_req (num_req),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i     (req),
    .last_i    (gnt_id_q),
    .pick_o    (pick),
    .pick_id_o (pick_id),
    .any_o     (pick_any)
  );

  // gnt_q is zero outside BURST, so reset alone is enough to kill wput/ack.
  assign grantee_req = |(req & gnt_q);
  assign wput        = grantee_req & ~wfull & (state_q == S_BURST);
  assign ack         = wput ? gnt_q : '0;
  assign wdata       = slot[gnt_id_q];
  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign busy        = (state_q == S_BURST);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    bcnt_d   = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d  = S_BURST;
          gnt_d    = pick;
          gnt_id_d = pick_id;
          bcnt_d   = '0;
        end
      end
      S_BURST: begin
        if (wput) bcnt_d = bcnt_q + 1'b1;
        // A stalled burst (wfull) keeps its grant; only a final beat or a drop ends it.
        if ((wput && (bcnt_q == LAST_BEAT)) || !grantee_req) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= RST_ID;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      bcnt_q   <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_k_wput_arb.sv
// Directed checks of k_wput_arb: reset, rotation, single requester,
// backpressure, early release, reset mid-burst, plus a random invariant run.
module tb_k_wput_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              wclk = 1'b0;
  logic              wrst_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic              wfull;
  logic              wput;
  logic [DW-1:0]     wdata;
  logic [NR-1:0]     gnt;
  logic [1:0]        gnt_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  k_wput_arb #(
    .num_req   (NR),
    .data_size (DW),
    .max_burst (MB)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .wfull    (wfull),
    .wput     (wput),
    .wdata    (wdata),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic test_reset();
    wrst_n   = 1'b0;
    req      = 4'b1111;
    wfull    = 1'b0;
    req_data = 32'h13121110;
    #12;
    checks++;
    if ({gnt, busy, wput, ack, gnt_id} !== {4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3}) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {gnt, busy, wput, ack, gnt_id},
               {4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3});
    end
    req = 4'b0000;
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    $display("reset: gnt=%b gnt_id=%0d", gnt, gnt_id);
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] exp_d;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << order[g];
      exp_d  = 8'h10 + 8'(order[g]);
      for (int b = 0; b < MB; b++) begin
        tick();
        checks++;
        if ({busy, wput, ack, gnt_id, wdata} !== {1'b1, 1'b1, exp_oh, 2'(order[g]), exp_d}) begin
          errors++;
          $display("FAIL rotation_beat g=%0d b=%0d got=%h exp=%h", g, b,
                   {busy, wput, ack, gnt_id, wdata}, {1'b1, 1'b1, exp_oh, 2'(order[g]), exp_d});
        end
        $display("rotation: grant=%0d beat=%0d ack=%b wdata=%h", order[g], b, ack, wdata);
      end
      tick();
      checks++;
      if ({busy, wput, ack} !== {1'b0, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL rotation_gap g=%0d got=%b exp=%b", g, {busy, wput, ack}, 6'b0);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_slot(2, 8'hA5);
    #1;
    checks++;
    if ({gnt, wput} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL single_latency got=%b exp=%b", {gnt, wput}, 5'b0);
    end
    for (int b = 0; b < MB; b++) begin
      tick();
      checks++;
      if ({gnt, wput, ack, wdata} !== {4'b0100, 1'b1, 4'b0100, 8'hA5}) begin
        errors++;
        $display("FAIL single_beat b=%0d got=%h exp=%h", b, {gnt, wput, ack, wdata},
                 {4'b0100, 1'b1, 4'b0100, 8'hA5});
      end
      $display("single: beat=%0d ack=%b wdata=%h", b, ack, wdata);
    end
    tick();
    checks++;
    if ({busy, wput, gnt} !== {1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL single_gap got=%b exp=%b", {busy, wput, gnt}, 6'b0);
    end
    tick();
    checks++;
    if ({gnt, gnt_id, wput} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_regrant got=%b exp=%b", {gnt, gnt_id, wput}, {4'b0100, 2'd2, 1'b1});
    end
    req = 4'b0000;
    #1;
    checks++;
    if (wput !== 1'b0) begin
      errors++;
      $display("FAIL single_drop_wput got=%b exp=0", wput);
    end
    tick();
    checks++;
    if ({busy, gnt} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL single_release got=%b exp=%b", {busy, gnt}, 5'b0);
    end
  endtask

  task automatic test_backpressure();
    req = 4'b1000;
    set_slot(3, 8'h30);
    tick();
    checks++;
    if ({gnt, wput, wdata} !== {4'b1000, 1'b1, 8'h30}) begin
      errors++;
      $display("FAIL bp_beat1 got=%h exp=%h", {gnt, wput, wdata}, {4'b1000, 1'b1, 8'h30});
    end
    tick();
    set_slot(3, 8'h31);
    #1;
    checks++;
    if ({wput, wdata} !== {1'b1, 8'h31}) begin
      errors++;
      $display("FAIL bp_beat2 got=%h exp=%h", {wput, wdata}, {1'b1, 8'h31});
    end
    tick();
    set_slot(3, 8'h32);
    wfull = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      #1;
      checks++;
      if ({busy, wput, ack, gnt} !== {1'b1, 1'b0, 4'b0000, 4'b1000}) begin
        errors++;
        $display("FAIL bp_stall s=%0d got=%b exp=%b", s, {busy, wput, ack, gnt},
                 {1'b1, 1'b0, 4'b0000, 4'b1000});
      end
      $display("backpressure: stall=%0d wput=%b", s, wput);
    end
    tick();
    wfull = 1'b0;
    #1;
    checks++;
    if ({wput, ack, wdata} !== {1'b1, 4'b1000, 8'h32}) begin
      errors++;
      $display("FAIL bp_beat3 got=%h exp=%h", {wput, ack, wdata}, {1'b1, 4'b1000, 8'h32});
    end
    tick();
    set_slot(3, 8'h33);
    #1;
    checks++;
    if ({wput, wdata} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL bp_beat4 got=%h exp=%h", {wput, wdata}, {1'b1, 8'h33});
    end
    tick();
    checks++;
    if ({busy, wput} !== 2'b00) begin
      errors++;
      $display("FAIL bp_end got=%b exp=00", {busy, wput});
    end
    req = 4'b0000;
  endtask

  task automatic test_early_release();
    int n1;
    n1  = 0;
    req = 4'b1010;
    set_slot(1, 8'h51);
    tick();
    n1 += int'(ack[1]);
    checks++;
    if ({gnt, ack, gnt_id} !== {4'b0010, 4'b0010, 2'd1}) begin
      errors++;
      $display("FAIL early_grant got=%b exp=%b", {gnt, ack, gnt_id}, {4'b0010, 4'b0010, 2'd1});
    end
    tick();
    n1 += int'(ack[1]);
    req = 4'b1000;
    #1;
    n1 += int'(ack[1]);
    checks++;
    if ({busy, wput, ack} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL early_drop got=%b exp=%b", {busy, wput, ack}, {1'b1, 1'b0, 4'b0000});
    end
    tick();
    checks++;
    if ({busy, gnt, n1} !== {1'b0, 4'b0000, 32'd2}) begin
      errors++;
      $display("FAIL early_release got busy=%b gnt=%b acks=%0d exp busy=0 gnt=0000 acks=2",
               busy, gnt, n1);
    end
    tick();
    checks++;
    if ({gnt, gnt_id, wput} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL early_next got=%b exp=%b", {gnt, gnt_id, wput}, {4'b1000, 2'd3, 1'b1});
    end
    $display("early_release: acks_from_1=%0d next_gnt=%b", n1, gnt);
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    set_slot(2, 8'h77);
    tick();
    tick();
    checks++;
    if ({gnt, wput} !== {4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_beat2 got=%b exp=%b", {gnt, wput}, {4'b0100, 1'b1});
    end
    #2;
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, wput, ack, gnt_id} !== {4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3}) begin
      errors++;
      $display("FAIL rstmid_async got=%b exp=%b", {gnt, busy, wput, ack, gnt_id},
               {4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3});
    end
    req = 4'b1111;
    @(negedge wclk);
    wrst_n = 1'b1;
    tick();
    checks++;
    if ({gnt, gnt_id, wput} !== {4'b0001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_first got=%b exp=%b", {gnt, gnt_id, wput}, {4'b0001, 2'd0, 1'b1});
    end
    $display("reset_mid: first grant after reset gnt=%b", gnt);
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random();
    int run_beats;
    int beats;
    logic [DW-1:0] exp_d;
    run_beats = 0;
    beats     = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if ($urandom_range(3) == 0) req = 4'($urandom);
      wfull    = ($urandom_range(3) == 0);
      req_data = $urandom;
      #1;
      if (!busy) run_beats = 0;
      checks++;
      if ((wput && wfull) || ((ack & (ack - 4'd1)) != 4'd0) || (!wput && ack != 4'd0)) begin
        errors++;
        $display("FAIL rand_invariant c=%0d wput=%b wfull=%b ack=%b", c, wput, wfull, ack);
      end
      if (wput) begin
        exp_d = '0;
        for (int i = 0; i < NR; i++) if (ack[i]) exp_d = req_data[i*DW +: DW];
        run_beats++;
        beats++;
        checks++;
        if ((wdata !== exp_d) || (ack !== gnt) || ((ack & req) !== ack) || (run_beats > MB)) begin
          errors++;
          $display("FAIL rand_beat c=%0d wdata=%h exp=%h ack=%b gnt=%b req=%b run=%0d max=%0d",
                   c, wdata, exp_d, ack, gnt, req, run_beats, MB);
        end
      end
    end
    $display("random: %0d beats written", beats);
    req   = 4'b0000;
    wfull = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_backpressure();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
